cmd_sequencer: RTL and testbench

Parametrised command sequencer that drives the RemoteComm-style 16-bit command interface autonomously. Replaces hand-scripted send/wait/timeout sequences with synthesizable logic. A queue of commands (calibrate, move, move-with-fanfare, tour) is loaded into an internal FIFO. On `start`, each command is issued in order, the 8-bit response is awaited under a per-command timeout, and an acknowledge count plus error status is reported. Sits between a host/bench controller and the RemoteComm `cmd`/`send_cmd`/`cmd_sent`/`resp_rdy`/`resp` ports.

---
 rtl/cmd_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 16-bit commands and issues them in order to a RemoteComm-style port.
// Each command waits for an ACK byte under a timeout. Define SEQ_RETRY_EN to reissue a failed command once.
module cmd_sequencer #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TMO_CYC = 4_000_000,
   parameter logic [7:0]  ACK     = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [15:0]            load_cmd,
   input  logic                   start,
   input  logic                   abort,
   output logic [15:0]            cmd,
   output logic                   send_cmd,
   input  logic                   cmd_sent,
   input  logic                   resp_rdy,
   input  logic [7:0]             resp,
   output logic                   full,
   output logic                   empty,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [$clog2(DEPTH):0] ack_cnt,
   output logic                   ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TMO_CYC + 1);

   localparam logic [1:0] E_NAK   = 2'b01;
   localparam logic [1:0] E_TMO   = 2'b10;
   localparam logic [1:0] E_EARLY = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_SENT,
      S_WAIT_RESP,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_n;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_n;
   logic            push, pop, flush;
   logic [15:0]     head_n;
   logic [TW-1:0]   tmo_q, tmo_n;
   logic [15:0]     cmd_n;
   logic            send_n, busy_n, done_n, err_n;
   logic [1:0]      code_n, fail_code;
   logic [CW-1:0]   ack_n;
   logic            fail, resp_phase;
`ifdef SEQ_RETRY_EN
   logic            retried_q, retried_n;
`endif

   // FIFO bookkeeping; a push into a full FIFO is allowed when the head pops the same cycle
   always_comb begin
      push    = load && !flush && ((count != CW'(DEPTH)) || pop);
      count_n = flush ? '0 : CW'(count + CW'(push) - CW'(pop));
      head_n  = pop ? mem[AW'(rd_ptr + 1'b1)] : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= load_cmd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
         end
         count <= count_n;
         full  <= (count_n == CW'(DEPTH));
         empty <= (count_n == '0);
         if (load && !push && !flush) ovf <= 1'b1;
      end
   end

   // next-state and output decode
   always_comb begin
      state_n    = state_q;
      pop        = 1'b0;
      flush      = 1'b0;
      tmo_n      = tmo_q;
      done_n     = done;
      err_n      = err;
      code_n     = err_code;
      ack_n      = ack_cnt;
      fail       = 1'b0;
      fail_code  = 2'b00;
      resp_phase = 1'b0;
`ifdef SEQ_RETRY_EN
      retried_n  = retried_q;
`endif

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               ack_n  = '0;
               done_n = 1'b0;
               err_n  = 1'b0;
               code_n = 2'b00;
`ifdef SEQ_RETRY_EN
               retried_n = 1'b0;
`endif
               if (count != '0) begin
                  state_n = S_ISSUE;
               end else begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            tmo_n   = TW'(TMO_CYC - 1);
            state_n = S_WAIT_SENT;
         end
         S_WAIT_SENT, S_WAIT_RESP: begin
            if (tmo_q != '0) tmo_n = TW'(tmo_q - 1'b1);
            // a response in the same cycle as cmd_sent counts as arriving after it
            resp_phase = (state_q == S_WAIT_RESP) || cmd_sent;
            if (resp_rdy && !resp_phase) begin
               state_n = S_ERR;
               err_n   = 1'b1;
               code_n  = E_EARLY;
            end else if (resp_rdy) begin
               if (resp == ACK) begin
                  pop   = 1'b1;
                  ack_n = CW'(ack_cnt + 1'b1);
`ifdef SEQ_RETRY_EN
                  retried_n = 1'b0;
`endif
                  if (count > CW'(1)) begin
                     state_n = S_ISSUE;
                  end else begin
                     state_n = S_DONE;
                     done_n  = 1'b1;
                  end
               end else begin
                  fail      = 1'b1;
                  fail_code = E_NAK;
               end
            end else if (state_q == S_WAIT_SENT && cmd_sent) begin
               state_n = S_WAIT_RESP;
            end else if (tmo_q == '0) begin
               fail      = 1'b1;
               fail_code = E_TMO;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (fail) begin
`ifdef SEQ_RETRY_EN
         if (!retried_q) begin
            retried_n = 1'b1;
            state_n   = S_ISSUE;
         end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
            code_n  = fail_code;
         end
`else
         state_n = S_ERR;
         err_n   = 1'b1;
         code_n  = fail_code;
`endif
      end

      // abort discards this cycle's outcome but keeps the reported status
      if (abort) begin
         state_n = S_IDLE;
         flush   = 1'b1;
         pop     = 1'b0;
         done_n  = done;
         err_n   = err;
         code_n  = err_code;
         ack_n   = ack_cnt;
`ifdef SEQ_RETRY_EN
         retried_n = 1'b0;
`endif
      end

      send_n = (state_n == S_ISSUE);
      busy_n = (state_n == S_ISSUE) || (state_n == S_WAIT_SENT) || (state_n == S_WAIT_RESP);
      cmd_n  = send_n ? head_n : cmd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tmo_q    <= '0;
         cmd      <= '0;
         send_cmd <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         ack_cnt  <= '0;
      end else begin
         state_q  <= state_n;
         tmo_q    <= tmo_n;
         cmd      <= cmd_n;
         send_cmd <= send_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
         err_code <= code_n;
         ack_cnt  <= ack_n;
      end
   end

`ifdef SEQ_RETRY_EN
   always_ff @(posedge clk) begin
      if (rst) retried_q <= 1'b0;
      else     retried_q <= retried_n;
   end
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: randomized scoreboard bench for cmd_sequencer against a queue-based reference model.
module tb_cmd_sequencer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TMO_CYC = 100;
   localparam logic [7:0]  ACK     = 8'hA5;
`ifdef SEQ_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst, load, start, abort, cmd_sent, resp_rdy;
   logic [15:0]            load_cmd, cmd;
   logic [7:0]             resp;
   logic                   send_cmd, full, empty, busy, done, err, ovf;
   logic [1:0]             err_code;
   logic [$clog2(DEPTH):0] ack_cnt;

   int total = 0;
   int bad   = 0;

   logic [15:0] mq[$];
   logic [15:0] exp_cmd[$];
   bit          movf = 1'b0;

   cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYC(TMO_CYC), .ACK(ACK)) dut (
      .clk(clk), .rst(rst), .load(load), .load_cmd(load_cmd), .start(start), .abort(abort),
      .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
      .full(full), .empty(empty), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .ack_cnt(ack_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // monitor: every issue strobe must match the next expected command
   always @(negedge clk) begin
      if (!rst && send_cmd) begin
         if (exp_cmd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_send: cmd=%h, required no issue", cmd);
         end else begin
            chk("cmd", int'(cmd), int'(exp_cmd.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic reset_checks();
      chk("rst_cmd", cmd, 0);      chk("rst_send", send_cmd, 0);
      chk("rst_done", done, 0);    chk("rst_err", err, 0);
      chk("rst_code", err_code, 0); chk("rst_ack", ack_cnt, 0);
      chk("rst_ovf", ovf, 0);      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);  chk("rst_busy", busy, 0);
   endtask

   task automatic check_status(input bit d, input bit e, input int code, input int ack);
      chk("done", done, d);
      chk("err", err, e);
      chk("err_code", err_code, code);
      chk("ack_cnt", ack_cnt, ack);
      chk("empty", empty, int'(mq.size() == 0));
      chk("full", full, int'(mq.size() == DEPTH));
      chk("busy", busy, 0);
      chk("ovf", ovf, movf);
   endtask

   task automatic do_load(input logic [15:0] c);
      load_cmd = c;
      load     = 1'b1;
      if (mq.size() < DEPTH) mq.push_back(c);
      else                   movf = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      mq.delete();
      chk("abort_busy", busy, 0);
      chk("abort_empty", empty, 1);
   endtask

   task automatic wait_send(output int lat);
      lat = 0;
      while (!send_cmd && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!send_cmd) begin
         total++;
         bad++;
         $display("FAIL send_wait: no send_cmd within %0d cycles, required one", lat);
      end
   endtask

   // RemoteComm responder: cmd_sent after a random delay, response with it or a little later
   task automatic respond(input logic [7:0] r);
      bit both;
      both = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      cmd_sent = 1'b1;
      if (both) begin
         resp_rdy = 1'b1;
         resp     = r;
      end
      @(negedge clk);
      cmd_sent = 1'b0;
      if (!both) begin
         resp_rdy = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         resp_rdy = 1'b1;
         resp     = r;
         @(negedge clk);
      end
      resp_rdy = 1'b0;
   endtask

   // start the queue and answer each issue; model decides expected order and final status
   task automatic run_seq(input int nak_pct);
      int          ack;
      int          lat;
      bit          retried;
      logic [7:0]  r;
      ack     = 0;
      retried = 1'b0;
      if (mq.size() == 0) begin
         pulse_start();
         check_status(1, 0, 0, 0);
         return;
      end
      exp_cmd.push_back(mq[0]);
      pulse_start();
      forever begin
         wait_send(lat);
         chk("issue_lat", lat, 0);
         if ($urandom_range(0, 99) < nak_pct) begin
            r = 8'($urandom_range(0, 255));
            if (r == ACK) r = 8'h5A;
         end else begin
            r = ACK;
         end
         if (r == ACK) begin
            void'(mq.pop_front());
            ack++;
            retried = 1'b0;
            if (mq.size() > 0) exp_cmd.push_back(mq[0]);
            respond(r);
            if (mq.size() == 0) begin
               check_status(1, 0, 0, ack);
               break;
            end
         end else if (RETRY && !retried) begin
            retried = 1'b1;
            exp_cmd.push_back(mq[0]);
            respond(r);
         end else begin
            respond(r);
            check_status(0, 1, 1, ack);
            break;
         end
      end
   endtask

   task automatic tmo_test(input bit with_sent);
      int lat, n, t_s2, t_e;
      do_abort();
      do_load(16'($urandom));
      exp_cmd.push_back(mq[0]);
      if (RETRY) exp_cmd.push_back(mq[0]);
      pulse_start();
      wait_send(lat);
      n    = 0;
      t_s2 = -1;
      t_e  = -1;
      while (t_e < 0 && n < 3 * TMO_CYC) begin
         @(negedge clk);
         n++;
         cmd_sent = with_sent && (n == 2);
         if (send_cmd && t_s2 < 0) t_s2 = n;
         if (err) t_e = n;
      end
      cmd_sent = 1'b0;
      if (RETRY) begin
         chk("retry_send_at", t_s2, TMO_CYC + 1);
         chk("tmo_err_at", t_e, 2 * (TMO_CYC + 1));
      end else begin
         chk("tmo_err_at", t_e, TMO_CYC + 1);
      end
      check_status(0, 1, 2, 0);
   endtask

   initial begin
      int lat;
      rst = 1'b1; load = 1'b0; load_cmd = '0; start = 1'b0; abort = 1'b0;
      cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
      repeat (3) @(negedge clk);
      reset_checks();
      rst = 1'b0;
      @(negedge clk);

      // three commands, all acknowledged
      do_load(16'h2000); do_load(16'h43F1); do_load(16'h4BF1);
      run_seq(0);

      // NAK leaves the head queued; a restart reissues it
      do_load(16'h4001);
      run_seq(100);
      run_seq(0);

      // start with an empty queue goes straight to done
      do_abort();
      run_seq(0);

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) != 0) do_abort();
         repeat ($urandom_range(1, DEPTH)) do_load(16'($urandom));
         run_seq(30);
      end

      // overflow: DEPTH+1 loads, only DEPTH issued
      do_abort();
      for (int i = 0; i < DEPTH - 1; i++) do_load(16'($urandom));
      chk("not_full", full, 0);
      do_load(16'($urandom));
      chk("full", full, 1);
      do_load(16'hDEAD);
      chk("ovf", ovf, 1);
      run_seq(0);

      tmo_test(1'b0);
      tmo_test(1'b1);

      // response on the counter's final cycle beats the timeout
      do_abort();
      do_load(16'h1234);
      exp_cmd.push_back(mq[0]);
      pulse_start();
      wait_send(lat);
      for (int n = 1; n <= TMO_CYC; n++) begin
         @(negedge clk);
         cmd_sent = (n == 1);
         resp_rdy = (n == TMO_CYC);
         resp     = ACK;
      end
      @(negedge clk);
      resp_rdy = 1'b0;
      void'(mq.pop_front());
      check_status(1, 0, 0, 1);

      // abort while waiting for the second of four responses
      for (int i = 0; i < 4; i++) do_load(16'($urandom));
      exp_cmd.push_back(mq[0]);
      pulse_start();
      wait_send(lat);
      void'(mq.pop_front());
      exp_cmd.push_back(mq[0]);
      respond(ACK);
      wait_send(lat);
      chk("issue_lat", lat, 0);
      @(negedge clk); cmd_sent = 1'b1;
      @(negedge clk); cmd_sent = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      mq.delete();
      chk("abort_send", send_cmd, 0);
      check_status(0, 0, 0, 1);
      repeat (10) @(negedge clk);

      // response before cmd_sent
      do_load(16'h0F0F);
      exp_cmd.push_back(mq[0]);
      pulse_start();
      wait_send(lat);
      @(negedge clk); resp_rdy = 1'b1; resp = ACK;
      @(negedge clk); resp_rdy = 1'b0;
      check_status(0, 1, 3, 0);

      // reset in the middle of WAIT_RESP
      exp_cmd.push_back(mq[0]);
      pulse_start();
      wait_send(lat);
      @(negedge clk); cmd_sent = 1'b1;
      @(negedge clk); cmd_sent = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      mq.delete();
      movf = 1'b0;
      reset_checks();
      rst = 1'b0;

      repeat (5) @(negedge clk);
      chk("exp_left", exp_cmd.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
